// File: rtl/imem_arbiter.sv
// Program-memory port arbiter between instruction fetch and the boot loader.
// Define IMEM_ARB_PERF_EN to build the fetch/loader conflict counter.
module imem_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  input  logic              l_done,
  input  logic              l_reboot,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_hold,
  output logic [ADDR_W:0]   prog_words,
  output logic [31:0]       perf_conflicts,
  output logic              dbg_state,
  output logic [ADDR_W:0]   dbg_word_cnt
);
  // Handshake: a requester holds *_req with its address/data; *_gnt high in the
  // same cycle means the memory took the access. There is no back-pressure on
  // returns: a granted read answers with *_rvalid exactly one cycle later.

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0]   STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [ADDR_W:0] WORD_SAT   = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic [SW-1:0]   starve_cnt;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] word_cnt_inc;
  logic            f_rvalid_q;
  logic            l_rvalid_q;
  logic            l_wr;

  always_comb begin
    f_gnt    = 1'b0;
    l_gnt    = 1'b0;
    cpu_hold = 1'b1;
    if (state == ST_BOOT) begin
      l_gnt = l_req;
    end else begin
      if (f_req && l_req) begin
        // Fetch has priority until the loader has waited STARVE_MAX times.
        if (starve_cnt == STARVE_LIM) l_gnt = 1'b1;
        else                          f_gnt = 1'b1;
      end else begin
        f_gnt = f_req;
        l_gnt = l_req;
      end
      cpu_hold = f_req & ~f_gnt;
    end
  end

  assign l_wr         = l_gnt & l_we;
  assign word_cnt_inc = (l_wr && (word_cnt != WORD_SAT))
                        ? word_cnt + {{ADDR_W{1'b0}}, 1'b1} : word_cnt;

  assign mem_en    = f_gnt | l_gnt;
  assign mem_we    = l_wr;
  assign mem_addr  = f_gnt ? f_addr : (l_gnt ? l_addr : '0);
  assign mem_wdata = l_gnt ? l_wdata : '0;

  assign f_rvalid = f_rvalid_q;
  assign l_rvalid = l_rvalid_q;
  assign f_rdata  = f_rvalid_q ? mem_rdata : '0;
  assign l_rdata  = l_rvalid_q ? mem_rdata : '0;

  assign dbg_state    = state;
  assign dbg_word_cnt = word_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_BOOT;
      starve_cnt <= '0;
      word_cnt   <= '0;
      prog_words <= '0;
      f_rvalid_q <= 1'b0;
      l_rvalid_q <= 1'b0;
    end else begin
      f_rvalid_q <= f_gnt;
      l_rvalid_q <= l_gnt & ~l_we;
      if (state == ST_BOOT) begin
        if (l_reboot) begin
          word_cnt <= '0;
        end else begin
          word_cnt <= word_cnt_inc;
          if (l_done) begin
            state      <= ST_RUN;
            prog_words <= word_cnt_inc;
            starve_cnt <= '0;
          end
        end
      end else begin
        starve_cnt <= (l_req && f_gnt) ? starve_cnt + SW'(1) : '0;
        if (l_reboot) begin
          state    <= ST_BOOT;
          word_cnt <= '0;
        end
      end
    end
  end

`ifdef IMEM_ARB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_q <= '0;
    end else if (state == ST_BOOT) begin
      if (l_done && !l_reboot) perf_q <= '0;
    end else if (f_req && l_req && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_conflicts = perf_q;
`else
  assign perf_conflicts = 32'h0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed table, hand sequences, random traffic against
// a cycle-level reference model, and loader word-count saturation.
`timescale 1ns/1ps
module tb_imem_arbiter;
  localparam int ADDR_W     = 14;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int MEM_WORDS  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              f_req = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0;
  logic              f_gnt, f_rvalid;
  logic [DATA_W-1:0] f_rdata;
  logic              l_req = 1'b0, l_we = 1'b0;
  logic [ADDR_W-1:0] l_addr = '0;
  logic [DATA_W-1:0] l_wdata = '0;
  logic              l_done = 1'b0, l_reboot = 1'b0;
  logic              l_gnt, l_rvalid;
  logic [DATA_W-1:0] l_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              cpu_hold;
  logic [ADDR_W:0]   prog_words;
  logic [31:0]       perf_conflicts;
  logic              dbg_state;
  logic [ADDR_W:0]   dbg_word_cnt;

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_done(l_done), .l_reboot(l_reboot),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cpu_hold(cpu_hold), .prog_words(prog_words),
    .perf_conflicts(perf_conflicts), .dbg_state(dbg_state), .dbg_word_cnt(dbg_word_cnt)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Synchronous program memory seen by the DUT.
  logic [DATA_W-1:0] mem_arr [MEM_WORDS];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] = mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  // ---------------- stimulus records ----------------
  typedef struct {
    logic              fr;
    logic [ADDR_W-1:0] fa;
    logic              lr;
    logic              lw;
    logic [ADDR_W-1:0] la;
    logic [DATA_W-1:0] lwd;
    logic              ld;
    logic              lrb;
  } in_t;

  typedef struct {
    in_t               in;
    logic              fg, lg, hold, frv, lrv, run;
    logic [DATA_W-1:0] frd, lrd;
    logic [ADDR_W:0]   prog;
  } vec_t;

  function automatic in_t mki(logic fr, logic [ADDR_W-1:0] fa, logic lr, logic lw,
                              logic [ADDR_W-1:0] la, logic [DATA_W-1:0] lwd,
                              logic ld, logic lrb);
    in_t s;
    s.fr = fr; s.fa = fa; s.lr = lr; s.lw = lw; s.la = la; s.lwd = lwd; s.ld = ld; s.lrb = lrb;
    return s;
  endfunction

  function automatic vec_t mk(in_t s, logic fg, logic lg, logic hold,
                              logic frv, logic [DATA_W-1:0] frd,
                              logic lrv, logic [DATA_W-1:0] lrd,
                              logic [ADDR_W:0] prog, logic run);
    vec_t v;
    v.in = s; v.fg = fg; v.lg = lg; v.hold = hold; v.frv = frv; v.frd = frd;
    v.lrv = lrv; v.lrd = lrd; v.prog = prog; v.run = run;
    return v;
  endfunction

  // ---------------- reference model / scoreboard ----------------
  int                n_checks = 0;
  int                n_fail   = 0;
  logic [DATA_W-1:0] ref_mem [MEM_WORDS];
  logic [DATA_W-1:0] f_exp_q[$];
  logic [DATA_W-1:0] l_exp_q[$];
  bit                m_run;
  int                m_wait;
  int                m_words;
  int                m_prog;
  longint            m_perf;
  in_t               cur;
  logic              e_fg, e_lg;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_wait = 0; m_words = 0; m_prog = 0; m_perf = 0;
    f_exp_q.delete();
    l_exp_q.delete();
  endtask

  // Drive one cycle's inputs at the falling edge and check all outputs.
  task automatic drive_and_check(input in_t s);
    logic              lturn, ehold;
    logic [ADDR_W-1:0] eaddr;
    logic              efrv, elrv;
    logic [DATA_W-1:0] efd, eld;
    logic [31:0]       eperf;
    cur = s;
    f_req = s.fr; f_addr = s.fa; l_req = s.lr; l_we = s.lw; l_addr = s.la;
    l_wdata = s.lwd; l_done = s.ld; l_reboot = s.lrb;
    #1;
    lturn = 1'b0;
    if (!m_run) begin
      e_fg = 1'b0;
      e_lg = s.lr;
    end else begin
      lturn = s.lr && (!s.fr || (m_wait >= STARVE_MAX));
      e_lg  = lturn;
      e_fg  = s.fr && !lturn;
    end
    ehold = !m_run || (s.fr && !e_fg);
    eaddr = e_fg ? s.fa : (e_lg ? s.la : '0);
    efrv  = (f_exp_q.size() != 0);
    efd   = efrv ? f_exp_q.pop_front() : '0;
    elrv  = (l_exp_q.size() != 0);
    eld   = elrv ? l_exp_q.pop_front() : '0;
`ifdef IMEM_ARB_PERF_EN
    eperf = m_perf[31:0];
`else
    eperf = 32'h0;
`endif
    chk("f_gnt",    64'(f_gnt),    64'(e_fg));
    chk("l_gnt",    64'(l_gnt),    64'(e_lg));
    chk("cpu_hold", 64'(cpu_hold), 64'(ehold));
    chk("mem_en",   64'(mem_en),   64'(e_fg | e_lg));
    chk("mem_we",   64'(mem_we),   64'(e_lg & s.lw));
    chk("mem_addr", 64'(mem_addr), 64'(eaddr));
    if (e_lg && s.lw) chk("mem_wdata", 64'(mem_wdata), 64'(s.lwd));
    chk("f_rvalid", 64'(f_rvalid), 64'(efrv));
    chk("f_rdata",  64'(f_rdata),  64'(efd));
    chk("l_rvalid", 64'(l_rvalid), 64'(elrv));
    chk("l_rdata",  64'(l_rdata),  64'(eld));
    chk("prog_words",     64'(prog_words),     64'(m_prog));
    chk("state",          64'(dbg_state),      64'(m_run));
    chk("word_cnt",       64'(dbg_word_cnt),   64'(m_words));
    chk("perf_conflicts", 64'(perf_conflicts), 64'(eperf));
  endtask

  // Clock edge: advance the model from the boot/run rules, return at the falling edge.
  task automatic advance();
    @(posedge clk);
    if (e_fg) f_exp_q.push_back(ref_mem[cur.fa]);
    if (e_lg && !cur.lw) l_exp_q.push_back(ref_mem[cur.la]);
    if (e_lg && cur.lw) ref_mem[cur.la] = cur.lwd;
    if (m_run) begin
      if (cur.fr && cur.lr && (m_perf < 64'hFFFF_FFFF)) m_perf++;
      m_wait = (cur.lr && e_fg) ? m_wait + 1 : 0;
      if (cur.lrb) begin
        m_run   = 1'b0;
        m_words = 0;
      end
    end else begin
      if (e_lg && cur.lw && (m_words < MEM_WORDS)) m_words++;
      if (cur.lrb) begin
        m_words = 0;
      end else if (cur.ld) begin
        m_prog = m_words;
        m_run  = 1'b1;
        m_wait = 0;
        m_perf = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic cycle(input in_t s);
    drive_and_check(s);
    advance();
  endtask

  // Pull reset low mid-cycle and check everything clears without a clock edge.
  task automatic async_reset(input string tag);
    l_req = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk({tag, "_f_rvalid"}, 64'(f_rvalid), 64'(0));
    chk({tag, "_f_rdata"},  64'(f_rdata),  64'(0));
    chk({tag, "_l_rvalid"}, 64'(l_rvalid), 64'(0));
    chk({tag, "_f_gnt"},    64'(f_gnt),    64'(0));
    chk({tag, "_l_gnt"},    64'(l_gnt),    64'(0));
    chk({tag, "_mem_en"},   64'(mem_en),   64'(0));
    chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(1));
    chk({tag, "_state"},    64'(dbg_state), 64'(0));
    chk({tag, "_prog"},     64'(prog_words), 64'(0));
    chk({tag, "_perf"},     64'(perf_conflicts), 64'(0));
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- test sequence ----------------
  vec_t tab[19];
  in_t  s;
  in_t  cf;

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) begin
      mem_arr[i] = '0;
      ref_mem[i] = '0;
    end
    model_reset();

    cf = mki(1, 1, 1, 0, 2, 0, 0, 0);
    tab[0]  = mk(mki(1, 0, 1, 1, 0, 32'h00500093, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tab[1]  = mk(mki(1, 0, 1, 1, 1, 32'h00100113, 0, 0), 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tab[2]  = mk(mki(1, 0, 1, 1, 2, 32'h002081B3, 1, 0), 0, 1, 1, 0, 0, 0, 0, 0, 0);
    tab[3]  = mk(mki(1, 1, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0, 0, 0, 0, 3, 1);
    tab[4]  = mk(mki(0, 1, 0, 0, 0, 0, 0, 0), 0, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[5]  = mk(cf, 1, 0, 0, 0, 0, 0, 0, 3, 1);
    tab[6]  = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[7]  = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[8]  = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[9]  = mk(cf, 0, 1, 1, 1, 32'h00100113, 0, 0, 3, 1);
    tab[10] = mk(cf, 1, 0, 0, 0, 0, 1, 32'h002081B3, 3, 1);
    tab[11] = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[12] = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[13] = mk(cf, 1, 0, 0, 1, 32'h00100113, 0, 0, 3, 1);
    tab[14] = mk(cf, 0, 1, 1, 1, 32'h00100113, 0, 0, 3, 1);
    tab[15] = mk(mki(0, 0, 1, 0, 2, 0, 0, 0), 0, 1, 0, 0, 0, 1, 32'h002081B3, 3, 1);
    tab[16] = mk(mki(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0, 1, 32'h002081B3, 3, 1);
    tab[17] = mk(mki(1, 0, 0, 0, 0, 0, 1, 1), 1, 0, 0, 0, 0, 0, 0, 3, 1);
    tab[18] = mk(mki(1, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 1, 32'h00500093, 0, 0, 3, 0);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_f_gnt",    64'(f_gnt),    64'(0));
    chk("rst_l_gnt",    64'(l_gnt),    64'(0));
    chk("rst_mem_en",   64'(mem_en),   64'(0));
    chk("rst_mem_we",   64'(mem_we),   64'(0));
    chk("rst_f_rvalid", 64'(f_rvalid), 64'(0));
    chk("rst_l_rvalid", 64'(l_rvalid), 64'(0));
    chk("rst_f_rdata",  64'(f_rdata),  64'(0));
    chk("rst_l_rdata",  64'(l_rdata),  64'(0));
    chk("rst_cpu_hold", 64'(cpu_hold), 64'(1));
    chk("rst_prog",     64'(prog_words), 64'(0));
    chk("rst_state",    64'(dbg_state),  64'(0));
    chk("rst_word_cnt", 64'(dbg_word_cnt), 64'(0));
    @(negedge clk);
    rst = 1'b1;

    // Directed table: boot load, fetch, starvation, loader read, reboot.
    for (int i = 0; i < 19; i++) begin
      drive_and_check(tab[i].in);
      chk($sformatf("row%0d_f_gnt", i),    64'(f_gnt),      64'(tab[i].fg));
      chk($sformatf("row%0d_l_gnt", i),    64'(l_gnt),      64'(tab[i].lg));
      chk($sformatf("row%0d_cpu_hold", i), 64'(cpu_hold),   64'(tab[i].hold));
      chk($sformatf("row%0d_f_rvalid", i), 64'(f_rvalid),   64'(tab[i].frv));
      chk($sformatf("row%0d_f_rdata", i),  64'(f_rdata),    64'(tab[i].frd));
      chk($sformatf("row%0d_l_rvalid", i), 64'(l_rvalid),   64'(tab[i].lrv));
      chk($sformatf("row%0d_l_rdata", i),  64'(l_rdata),    64'(tab[i].lrd));
      chk($sformatf("row%0d_prog", i),     64'(prog_words), 64'(tab[i].prog));
      chk($sformatf("row%0d_state", i),    64'(dbg_state),  64'(tab[i].run));
      advance();
      if (i == 14) begin
`ifdef IMEM_ARB_PERF_EN
        chk("perf_after_10", 64'(perf_conflicts), 64'(10));
`else
        chk("perf_tied_off", 64'(perf_conflicts), 64'(0));
`endif
      end
    end
    chk("reboot_word_cnt", 64'(dbg_word_cnt), 64'(0));
    chk("reboot_prog",     64'(prog_words),   64'(3));

    // Back to RUN, fetch, then reset while the read return is in flight.
    cycle(mki(0, 0, 0, 0, 0, 0, 1, 0));
    cycle(mki(1, 1, 0, 0, 0, 0, 0, 0));
    chk("pre_reset_f_rvalid", 64'(f_rvalid), 64'(1));
    async_reset("arst");

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      s.fr  = ($urandom_range(0, 3) != 0);
      s.fa  = ADDR_W'($urandom_range(0, 15));
      s.lr  = ($urandom_range(0, 1) == 1);
      s.lw  = ($urandom_range(0, 1) == 1);
      s.la  = ADDR_W'($urandom_range(0, 15));
      s.lwd = $urandom;
      s.ld  = ($urandom_range(0, 30) == 0);
      s.lrb = ($urandom_range(0, 60) == 0);
      cycle(s);
    end

    // Word-count saturation: one write more than the memory holds, the last with l_done.
    async_reset("arst2");
    for (int n = 0; n <= MEM_WORDS; n++) begin
      cycle(mki(0, 0, 1, 1, ADDR_W'(n), $urandom, (n == MEM_WORDS), 0));
    end
    chk("sat_prog",  64'(prog_words), 64'(MEM_WORDS));
    chk("sat_state", 64'(dbg_state),  64'(1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Shares the single synchronous program-memory port between two requesters: the instruction fetch unit and the program loader/debug port (UART loader).
- Sequences the boot flow: after reset the loader owns memory and the CPU is held; after load completes, fetch gets priority with bounded loader starvation.
- Sits between the fetch stage and the program memory, and drives the hold that freezes the PC.

Parameters:
- ADDR_W, 14, word-address width of program memory.
- DATA_W, 32, instruction/data word width.
- STARVE_MAX, 4, maximum consecutive fetch wins while the loader waits; must be ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- f_req  in  1  fetch read request.
- f_addr  in  ADDR_W  fetch word address.
- f_gnt  out  1  fetch granted this cycle.
- f_rvalid  out  1  fetch read data valid.
- f_rdata  out  DATA_W  fetch read data.
- l_req  in  1  loader request.
- l_we  in  1  loader write (1) / read (0).
- l_addr  in  ADDR_W  loader word address.
- l_wdata  in  DATA_W  loader write data.
- l_done  in  1  one-cycle pulse: load complete.
- l_reboot  in  1  one-cycle pulse: return to boot.
- l_gnt  out  1  loader granted this cycle.
- l_rvalid  out  1  loader read data valid.
- l_rdata  out  DATA_W  loader read data.
- mem_en  out  1  memory port enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid one cycle after mem_en with mem_we=0.
- cpu_hold  out  1  freeze PC/fetch.
- prog_words  out  ADDR_W+1  number of words written during the last boot.
- perf_conflicts  out  32  conflict counter (see Optional Feature).

Behaviour:
- Reset (async, rst=0):
  - state=BOOT; starve_cnt=0; word_cnt=0; prog_words=0.
  - f_gnt, l_gnt, f_rvalid, l_rvalid, mem_en and mem_we are all 0.
  - f_rdata and l_rdata are 0; cpu_hold=1.
- Grants are combinational from the current state and requests. The mem_* outputs mux the granted requester's signals; mem_en = f_gnt | l_gnt.
- Read return:
  - f_rvalid is registered: 1 exactly one cycle after a fetch grant.
  - l_rvalid is 1 exactly one cycle after a loader grant with l_we=0.
  - f_rdata and l_rdata show mem_rdata while their own rvalid=1, else 0.
- BOOT:
  - f_gnt=0, cpu_hold=1, l_gnt=l_req.
  - Each granted loader write increments word_cnt, saturating at 2^ADDR_W.
  - On l_done: next state is RUN, prog_words<=word_cnt including any write granted in the same cycle, starve_cnt<=0.
  - l_reboot in BOOT: word_cnt<=0, stay in BOOT.
- RUN arbitration:
  - Fetch only: f_gnt=1.
  - Loader only: l_gnt=1.
  - Both requesting: fetch wins unless starve_cnt==STARVE_MAX; in that case the loader wins.
- starve_cnt (RUN):
  - Increments when l_req=1 and fetch is granted.
  - Clears when the loader is granted or l_req=0.
- cpu_hold in RUN = f_req & ~f_gnt.
- l_done in RUN is ignored.
- l_reboot in RUN: next state BOOT, word_cnt<=0. The grant in that cycle is still issued by the RUN rules; its read return still completes next cycle.
- l_done and l_reboot in the same cycle: l_reboot wins.
- No request: mem_en=0 and mem_addr holds 0.

Optional Feature:
- Macro IMEM_ARB_PERF_EN.
- Defined: perf_conflicts counts RUN cycles with f_req & l_req.
  - Saturates at 32'hFFFF_FFFF.
  - Reset to 0 by rst and on every BOOT→RUN transition.
- Undefined: perf_conflicts tied to 32'h0 and no counter logic is synthesized.

Test Plan:
- Reset then load:
  - Stimulus: release rst; loader writes 3 words (addr 0,1,2 = 32'h00500093, 32'h00100113, 32'h002081B3); pulse l_done.
  - Required: cpu_hold=1 throughout BOOT and f_gnt=0 even with f_req=1; after l_done, prog_words=3 and state RUN.
- Fetch read:
  - Stimulus: in RUN, f_req=1, f_addr=1.
  - Required: f_gnt=1 in the same cycle; next cycle f_rvalid=1 and f_rdata=32'h00100113; cpu_hold=0.
- Starvation bound (STARVE_MAX=4):
  - Stimulus: f_req and l_req held high continuously.
  - Required: grants are F,F,F,F,L repeating; cpu_hold=1 only on the L cycles; with the macro, perf_conflicts=10 after 10 cycles.
- Loader read in RUN:
  - Stimulus: l_req=1, l_we=0, l_addr=2, f_req=0.
  - Required: l_gnt=1; next cycle l_rvalid=1 and l_rdata=32'h002081B3; f_rvalid=0.
- Reboot:
  - Stimulus: pulse l_reboot together with l_done during RUN.
  - Required: next state BOOT; cpu_hold=1; word_cnt=0; prog_words retains 3.
- Async reset mid-read:
  - Stimulus: assert rst low one cycle after f_gnt.
  - Required: f_rvalid=0 immediately (no clock edge needed); state BOOT; all grants 0.
